// File: rtl/exc_ctrl.sv
// exc_ctrl: exception / interrupt / ERET sequencer sitting in front of CP0.
// Turns a commit-point request into one cycle of CP0 write strobes followed
// by one cycle of flush + fetch redirect, then returns to idle.
// Optional feature macro: EXC_STATS_EN (exception counter on exc_count).
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h8000_0180,
  parameter logic [31:0] REFILL_VECTOR = 32'h8000_0000,
  parameter int unsigned NUM_INT       = 6
) (
  input  logic               clk,
  input  logic               res,
  input  logic               exc_valid,
  input  logic [4:0]         exc_code,
  input  logic [31:0]        exc_pc,
  input  logic               exc_bd,
  input  logic               exc_bva_valid,
  input  logic [31:0]        exc_badvaddr,
  input  logic               exc_refill,
  input  logic               eret,
  input  logic               commit_valid,
  input  logic [31:0]        commit_pc,
  input  logic               commit_bd,
  input  logic [NUM_INT-1:0] hw_int,
  input  logic [31:0]        cp0_status,
  input  logic [31:0]        cp0_cause,
  input  logic [31:0]        cp0_epc,
  output logic               exc_ready,
  output logic [31:0]        in_epc,
  output logic [31:0]        in_status,
  output logic [31:0]        in_cause,
  output logic [31:0]        in_badVAddr,
  output logic               we_epc,
  output logic               we_status,
  output logic               we_cause,
  output logic               we_badVAddr,
  output logic               flush,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic               int_pending,
  output logic [31:0]        exc_count
);

  localparam int unsigned IPW      = 6;
  localparam int unsigned CODEW    = 5;
  localparam int unsigned XLEN     = 32;
  localparam logic [XLEN-1:0] EPC_ADJ  = XLEN'(4);
  localparam logic [XLEN-1:0] EXL_MASK = XLEN'(2);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t              state;
  logic                is_eret;     // sequence in flight is an ERET
  logic                use_refill;  // exception goes to the refill vector
  logic [NUM_INT-1:0]  ip_meta;
  logic [NUM_INT-1:0]  ip_sync;
  logic [IPW-1:0]      ip_ext;
  logic                status_ie;
  logic                status_exl;
  logic                take_trap;

  logic [CODEW-1:0]    ent_code;
  logic [XLEN-1:0]     ent_pc;
  logic                ent_bd;
  logic                ent_bva_valid;
  logic                ent_refill;
  logic [XLEN-1:0]     ent_badvaddr;
  logic [XLEN-1:0]     nxt_cause;
  logic [XLEN-1:0]     nxt_epc;

  assign status_ie  = cp0_status[0];
  assign status_exl = cp0_status[1];
  assign ip_ext     = IPW'(ip_sync);

  assign int_pending = (|(ip_ext & cp0_status[15:10])) & status_ie & ~status_exl;
  assign exc_ready   = (state == IDLE);

  // A synchronous exception wins over an interrupt; ERET is handled separately.
  assign take_trap = exc_valid | (int_pending & commit_valid);

  // Two-flop synchroniser for the asynchronous interrupt lines.
  always_ff @(posedge clk) begin
    if (res) begin
      ip_meta <= '0;
      ip_sync <= '0;
    end else begin
      ip_meta <= hw_int;
      ip_sync <= ip_meta;
    end
  end

  // Select the trap source fields: exception report, else interrupted commit.
  always_comb begin
    ent_code      = exc_code;
    ent_pc        = exc_pc;
    ent_bd        = exc_bd;
    ent_bva_valid = exc_bva_valid;
    ent_refill    = exc_refill;
    ent_badvaddr  = exc_badvaddr;
    if (!exc_valid) begin
      ent_code      = '0;
      ent_pc        = commit_pc;
      ent_bd        = commit_bd;
      ent_bva_valid = 1'b0;
      ent_refill    = 1'b0;
      ent_badvaddr  = '0;
    end
  end

  // Cause / EPC images for a trap; BD is not reported when EXL was already set.
  always_comb begin
    nxt_cause        = cp0_cause;
    nxt_cause[6:2]   = ent_code;
    nxt_cause[15:10] = ip_ext;
    nxt_cause[31]    = ent_bd & ~status_exl;
    nxt_epc          = ent_bd ? (ent_pc - EPC_ADJ) : ent_pc;
  end

  // Sequencer: strobes are registered on entry so they are valid in COMMIT.
  always_ff @(posedge clk) begin
    if (res) begin
      state       <= IDLE;
      is_eret     <= 1'b0;
      use_refill  <= 1'b0;
      we_epc      <= 1'b0;
      we_status   <= 1'b0;
      we_cause    <= 1'b0;
      we_badVAddr <= 1'b0;
      in_epc      <= '0;
      in_status   <= '0;
      in_cause    <= '0;
      in_badVAddr <= '0;
      flush       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      we_epc      <= 1'b0;
      we_status   <= 1'b0;
      we_cause    <= 1'b0;
      we_badVAddr <= 1'b0;
      in_epc      <= '0;
      in_status   <= '0;
      in_cause    <= '0;
      in_badVAddr <= '0;
      flush       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      case (state)
        IDLE: begin
          if (take_trap) begin
            state       <= COMMIT;
            is_eret     <= 1'b0;
            use_refill  <= ent_refill & ~status_exl;
            we_status   <= 1'b1;
            in_status   <= cp0_status | EXL_MASK;
            we_cause    <= 1'b1;
            in_cause    <= nxt_cause;
            we_epc      <= ~status_exl;
            in_epc      <= status_exl ? '0 : nxt_epc;
            we_badVAddr <= ent_bva_valid;
            in_badVAddr <= ent_bva_valid ? ent_badvaddr : '0;
          end else if (eret) begin
            state      <= COMMIT;
            is_eret    <= 1'b1;
            use_refill <= 1'b0;
            we_status  <= 1'b1;
            in_status  <= cp0_status & ~EXL_MASK;
          end
        end
        COMMIT: begin
          state    <= REDIRECT;
          flush    <= 1'b1;
          redirect <= 1'b1;
          if (is_eret) begin
            redirect_pc <= cp0_epc;
          end else begin
            redirect_pc <= use_refill ? REFILL_VECTOR : EXC_VECTOR;
          end
        end
        REDIRECT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef EXC_STATS_EN
  logic [XLEN-1:0] count_q;

  // Count traps (exceptions and interrupts) as they leave COMMIT.
  always_ff @(posedge clk) begin
    if (res) begin
      count_q <= '0;
    end else if ((state == COMMIT) && !is_eret) begin
      count_q <= count_q + XLEN'(1);
    end
  end

  assign exc_count = count_q;
`else
  assign exc_count = 32'd0;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: scenario bench for exc_ctrl with an expected-result queue.
`timescale 1ns/1ps
module tb_exc_ctrl;

  localparam int unsigned NUM_INT = 6;
`ifdef EXC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic               clk;
  logic               res;
  logic               exc_valid;
  logic [4:0]         exc_code;
  logic [31:0]        exc_pc;
  logic               exc_bd;
  logic               exc_bva_valid;
  logic [31:0]        exc_badvaddr;
  logic               exc_refill;
  logic               eret;
  logic               commit_valid;
  logic [31:0]        commit_pc;
  logic               commit_bd;
  logic [NUM_INT-1:0] hw_int;
  logic [31:0]        cp0_status;
  logic [31:0]        cp0_cause;
  logic [31:0]        cp0_epc;
  logic               exc_ready;
  logic [31:0]        in_epc;
  logic [31:0]        in_status;
  logic [31:0]        in_cause;
  logic [31:0]        in_badVAddr;
  logic               we_epc;
  logic               we_status;
  logic               we_cause;
  logic               we_badVAddr;
  logic               flush;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic               int_pending;
  logic [31:0]        exc_count;

  exc_ctrl #(.NUM_INT(NUM_INT)) dut (
    .clk(clk), .res(res),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_bva_valid(exc_bva_valid), .exc_badvaddr(exc_badvaddr), .exc_refill(exc_refill),
    .eret(eret), .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_bd(commit_bd),
    .hw_int(hw_int), .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .exc_ready(exc_ready),
    .in_epc(in_epc), .in_status(in_status), .in_cause(in_cause), .in_badVAddr(in_badVAddr),
    .we_epc(we_epc), .we_status(we_status), .we_cause(we_cause), .we_badVAddr(we_badVAddr),
    .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
    .int_pending(int_pending), .exc_count(exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One observed/expected sequence: commit strobes+data, redirect, timing.
  typedef struct packed {
    logic [3:0]  we;      // {epc, status, cause, badVAddr}
    logic [31:0] epc;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] bva;
    logic [1:0]  fr;      // {flush, redirect}
    logic [31:0] rpc;
    logic [31:0] count;
    logic [3:0]  lat;
    logic        ready_mid;
    logic        ready_end;
  } rec_t;

  rec_t        exp_q[$];
  int          n_cmp;
  int          n_err;
  logic [31:0] exp_count;

  task automatic clear_requests();
    exc_valid     = 1'b0;
    exc_code      = '0;
    exc_pc        = '0;
    exc_bd        = 1'b0;
    exc_bva_valid = 1'b0;
    exc_badvaddr  = '0;
    exc_refill    = 1'b0;
    eret          = 1'b0;
    commit_valid  = 1'b0;
    commit_pc     = '0;
    commit_bd     = 1'b0;
  endtask

  // Let the request be sampled, then record one whole sequence (bounded wait).
  task automatic observe(output rec_t o, output bit timed_out);
    o = '0;
    timed_out = 1'b0;
    @(posedge clk);
    #1;
    exc_valid    = 1'b0;
    eret         = 1'b0;
    commit_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (we_status === 1'b1) begin
        o.lat = 4'(i);
        break;
      end
    end
    if (o.lat == 4'd0) begin
      timed_out = 1'b1;
      return;
    end
    o.we        = {we_epc, we_status, we_cause, we_badVAddr};
    o.epc       = we_epc      ? in_epc      : 32'd0;
    o.status    = we_status   ? in_status   : 32'd0;
    o.cause     = we_cause    ? in_cause    : 32'd0;
    o.bva       = we_badVAddr ? in_badVAddr : 32'd0;
    o.ready_mid = exc_ready;
    @(negedge clk);
    o.fr    = {flush, redirect};
    o.rpc   = redirect_pc;
    o.count = exc_count;
    @(negedge clk);
    o.ready_end = exc_ready;
  endtask

  task automatic test_reset();
    res = 1'b1;
    clear_requests();
    hw_int = '0;
    cp0_status = 32'h0000_FC01;
    cp0_cause = '0;
    cp0_epc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({we_epc, we_status, we_cause, we_badVAddr, flush, redirect} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_strobes got=%b want=000000",
               {we_epc, we_status, we_cause, we_badVAddr, flush, redirect});
    end
    n_cmp++;
    if ({in_epc, in_status, in_cause, in_badVAddr, redirect_pc, exc_count} !== 192'd0) begin
      n_err++;
      $display("FAIL reset_data got=%h want=0",
               {in_epc, in_status, in_cause, in_badVAddr, redirect_pc, exc_count});
    end
    n_cmp++;
    if ({exc_ready, int_pending} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_ready got ready/pend=%b want=10", {exc_ready, int_pending});
    end
    res = 1'b0;
    exp_count = '0;
    @(negedge clk);
  endtask

  task automatic test_exc_basic();
    rec_t e, o;
    bit to;
    cp0_status = 32'h0000_FC01;
    cp0_cause  = 32'h0000_0000;
    e = '0;
    e.we = 4'b1110; e.epc = 32'h8000_1000; e.status = 32'h0000_FC03; e.cause = 32'h0000_0028;
    e.fr = 2'b11; e.rpc = 32'h8000_0180;
    if (STATS) exp_count += 32'd1;
    e.count = exp_count; e.lat = 4'd1; e.ready_mid = 1'b0; e.ready_end = 1'b1;
    exp_q.push_back(e);
    exc_valid = 1'b1; exc_code = 5'd10; exc_pc = 32'h8000_1000; exc_bd = 1'b0;
    observe(o, to);
    clear_requests();
    e = exp_q.pop_front();
    n_cmp++;
    if (to) begin
      n_err++;
      $display("FAIL exc_basic timeout got=no_strobe want=strobe");
    end else begin
      if ({o.we, o.epc, o.status, o.cause, o.bva} !== {e.we, e.epc, e.status, e.cause, e.bva}) begin
        n_err++;
        $display("FAIL exc_basic_commit got=%h want=%h", {o.we, o.epc, o.status, o.cause, o.bva},
                 {e.we, e.epc, e.status, e.cause, e.bva});
      end
      n_cmp++;
      if ({o.fr, o.rpc, o.count} !== {e.fr, e.rpc, e.count}) begin
        n_err++;
        $display("FAIL exc_basic_redirect got=%h want=%h", {o.fr, o.rpc, o.count}, {e.fr, e.rpc, e.count});
      end
      n_cmp++;
      if ({o.lat, o.ready_mid, o.ready_end} !== {e.lat, e.ready_mid, e.ready_end}) begin
        n_err++;
        $display("FAIL exc_basic_timing got=%h want=%h", {o.lat, o.ready_mid, o.ready_end},
                 {e.lat, e.ready_mid, e.ready_end});
      end
    end
  endtask

  // Refill TLB miss in a delay slot, with EXL clear (refill vector) and set.
  task automatic test_refill();
    rec_t e, o;
    bit to;
    for (int k = 0; k < 2; k++) begin
      cp0_status = (k == 0) ? 32'h0000_FC01 : 32'h0000_FC03;
      cp0_cause  = 32'h4000_0300;
      e = '0;
      e.we     = (k == 0) ? 4'b1111 : 4'b0111;
      e.epc    = (k == 0) ? 32'h0040_0004 : 32'h0;
      e.status = 32'h0000_FC03;
      e.cause  = (k == 0) ? 32'hC000_0308 : 32'h4000_0308;
      e.bva    = 32'h1234_5678;
      e.fr     = 2'b11;
      e.rpc    = (k == 0) ? 32'h8000_0000 : 32'h8000_0180;
      if (STATS) exp_count += 32'd1;
      e.count = exp_count; e.lat = 4'd1; e.ready_mid = 1'b0; e.ready_end = 1'b1;
      exp_q.push_back(e);
      exc_valid = 1'b1; exc_code = 5'd2; exc_refill = 1'b1; exc_bd = 1'b1;
      exc_pc = 32'h0040_0008; exc_bva_valid = 1'b1; exc_badvaddr = 32'h1234_5678;
      observe(o, to);
      clear_requests();
      e = exp_q.pop_front();
      n_cmp++;
      if (to) begin
        n_err++;
        $display("FAIL refill%0d timeout got=no_strobe want=strobe", k);
      end else begin
        if ({o.we, o.epc, o.status, o.cause, o.bva} !== {e.we, e.epc, e.status, e.cause, e.bva}) begin
          n_err++;
          $display("FAIL refill%0d_commit got=%h want=%h", k, {o.we, o.epc, o.status, o.cause, o.bva},
                   {e.we, e.epc, e.status, e.cause, e.bva});
        end
        n_cmp++;
        if ({o.fr, o.rpc, o.count, o.lat, o.ready_end} !== {e.fr, e.rpc, e.count, e.lat, e.ready_end}) begin
          n_err++;
          $display("FAIL refill%0d_redirect got=%h want=%h", k, {o.fr, o.rpc, o.count, o.lat, o.ready_end},
                   {e.fr, e.rpc, e.count, e.lat, e.ready_end});
        end
      end
    end
  endtask

  task automatic test_interrupt();
    rec_t e, o;
    bit to;
    bit busy;
    cp0_status = 32'h0000_0401;
    cp0_cause  = 32'h0;
    hw_int = 6'b000001;
    @(negedge clk);
    n_cmp++;
    if (int_pending !== 1'b0) begin
      n_err++;
      $display("FAIL int_sync_1cyc got=%b want=0", int_pending);
    end
    @(negedge clk);
    n_cmp++;
    if (int_pending !== 1'b1) begin
      n_err++;
      $display("FAIL int_sync_2cyc got=%b want=1", int_pending);
    end
    cp0_status = 32'h0000_0400;
    commit_valid = 1'b1; commit_pc = 32'h0000_0100; commit_bd = 1'b0;
    busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (exc_ready !== 1'b1 || we_status !== 1'b0 || int_pending !== 1'b0) busy = 1'b1;
    end
    n_cmp++;
    if (busy) begin
      n_err++;
      $display("FAIL int_masked_ie0 got=entered want=idle");
    end
    cp0_status = 32'h0000_0401;
    e = '0;
    e.we = 4'b1110; e.epc = 32'h0000_0100; e.status = 32'h0000_0403; e.cause = 32'h0000_0400;
    e.fr = 2'b11; e.rpc = 32'h8000_0180;
    if (STATS) exp_count += 32'd1;
    e.count = exp_count; e.lat = 4'd1; e.ready_mid = 1'b0; e.ready_end = 1'b1;
    exp_q.push_back(e);
    observe(o, to);
    clear_requests();
    hw_int = '0;
    e = exp_q.pop_front();
    n_cmp++;
    if (to) begin
      n_err++;
      $display("FAIL int_take timeout got=no_strobe want=strobe");
    end else begin
      if ({o.we, o.epc, o.status, o.cause, o.bva} !== {e.we, e.epc, e.status, e.cause, e.bva}) begin
        n_err++;
        $display("FAIL int_commit got=%h want=%h", {o.we, o.epc, o.status, o.cause, o.bva},
                 {e.we, e.epc, e.status, e.cause, e.bva});
      end
      n_cmp++;
      if ({o.fr, o.rpc, o.count, o.lat, o.ready_end} !== {e.fr, e.rpc, e.count, e.lat, e.ready_end}) begin
        n_err++;
        $display("FAIL int_redirect got=%h want=%h", {o.fr, o.rpc, o.count, o.lat, o.ready_end},
                 {e.fr, e.rpc, e.count, e.lat, e.ready_end});
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_eret();
    rec_t e, o;
    bit to;
    cp0_status = 32'h0000_0003;
    cp0_epc    = 32'h8000_2000;
    e = '0;
    e.we = 4'b0100; e.status = 32'h0000_0001;
    e.fr = 2'b11; e.rpc = 32'h8000_2000;
    e.count = exp_count; e.lat = 4'd1; e.ready_mid = 1'b0; e.ready_end = 1'b1;
    exp_q.push_back(e);
    eret = 1'b1;
    observe(o, to);
    clear_requests();
    e = exp_q.pop_front();
    n_cmp++;
    if (to) begin
      n_err++;
      $display("FAIL eret timeout got=no_strobe want=strobe");
    end else begin
      if ({o.we, o.epc, o.status, o.cause, o.bva} !== {e.we, e.epc, e.status, e.cause, e.bva}) begin
        n_err++;
        $display("FAIL eret_commit got=%h want=%h", {o.we, o.epc, o.status, o.cause, o.bva},
                 {e.we, e.epc, e.status, e.cause, e.bva});
      end
      n_cmp++;
      if ({o.fr, o.rpc, o.count, o.lat, o.ready_mid, o.ready_end} !==
          {e.fr, e.rpc, e.count, e.lat, e.ready_mid, e.ready_end}) begin
        n_err++;
        $display("FAIL eret_redirect got=%h want=%h", {o.fr, o.rpc, o.count, o.lat, o.ready_mid, o.ready_end},
                 {e.fr, e.rpc, e.count, e.lat, e.ready_mid, e.ready_end});
      end
    end
  endtask

  // Request held high: only re-accepted once the block is idle again.
  task automatic test_back_to_back();
    logic [5:0] seen;
    cp0_status = 32'h0000_FC01;
    exc_valid = 1'b1; exc_code = 5'd9; exc_pc = 32'h0000_4000;
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen[i] = we_status;
    end
    clear_requests();
    if (STATS) exp_count += 32'd2;
    n_cmp++;
    if (seen !== 6'b001001) begin
      n_err++;
      $display("FAIL back_to_back_pattern got=%b want=001001", seen);
    end
    n_cmp++;
    if (exc_count !== exp_count) begin
      n_err++;
      $display("FAIL back_to_back_count got=%h want=%h", exc_count, exp_count);
    end
    repeat (2) @(negedge clk);
  endtask

  // All three requests at once: exception wins; then reset aborts in COMMIT.
  task automatic test_priority_reset();
    rec_t e;
    logic [3:0]  we_o;
    logic [95:0] dat_o;
    bit stray;
    cp0_status = 32'h0000_0401;
    cp0_cause  = 32'h0;
    hw_int = 6'b000001;
    repeat (3) @(negedge clk);
    e = '0;
    e.we = 4'b1110; e.epc = 32'h0000_0300; e.status = 32'h0000_0403; e.cause = 32'h0000_0430;
    exp_q.push_back(e);
    exc_valid = 1'b1; exc_code = 5'd12; exc_pc = 32'h0000_0300;
    eret = 1'b1;
    commit_valid = 1'b1; commit_pc = 32'h0000_0200;
    @(posedge clk);
    #1;
    clear_requests();
    @(negedge clk);
    we_o  = {we_epc, we_status, we_cause, we_badVAddr};
    dat_o = {in_epc, in_status, in_cause};
    e = exp_q.pop_front();
    n_cmp++;
    if ({we_o, dat_o} !== {e.we, e.epc, e.status, e.cause}) begin
      n_err++;
      $display("FAIL priority_commit got=%h want=%h", {we_o, dat_o}, {e.we, e.epc, e.status, e.cause});
    end
    res = 1'b1;
    hw_int = '0;
    @(posedge clk);
    #1;
    res = 1'b0;
    exp_count = '0;
    @(negedge clk);
    n_cmp++;
    if ({we_epc, we_status, we_cause, we_badVAddr, flush, redirect, exc_ready} !== 7'b0000001 ||
        {in_epc, in_status, in_cause, in_badVAddr, redirect_pc, exc_count} !== 192'd0) begin
      n_err++;
      $display("FAIL abort_outputs got=%b/%h want=0000001/0",
               {we_epc, we_status, we_cause, we_badVAddr, flush, redirect, exc_ready},
               {in_epc, in_status, in_cause, in_badVAddr, redirect_pc, exc_count});
    end
    stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (flush !== 1'b0 || redirect !== 1'b0 || we_status !== 1'b0) stray = 1'b1;
    end
    n_cmp++;
    if (stray) begin
      n_err++;
      $display("FAIL abort_no_redirect got=redirect want=none");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_count = '0;
    res = 1'b1;
    clear_requests();
    hw_int = '0;
    cp0_status = '0;
    cp0_cause = '0;
    cp0_epc = '0;
    test_reset();
    test_exc_basic();
    test_refill();
    test_interrupt();
    test_eret();
    test_back_to_back();
    test_priority_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt sequencer sitting directly upstream of the CP0 register file.
- Takes synchronous exception reports and ERET requests from the pipeline commit point, plus the external interrupt lines.
- Produces the in_*/we_* write strobes that update EPC/Status/Cause/BadVAddr, then flushes the pipeline and redirects fetch to the handler vector or EPC.

Parameters:
- EXC_VECTOR, 32'h8000_0180, general exception handler address.
- REFILL_VECTOR, 32'h8000_0000, TLB refill handler address (used only when Status.EXL=0).
- NUM_INT, 6, number of hardware interrupt lines, mapped to Cause.IP[7:2]; range 1..6.

Ports:
- clk  in  1  clock.
- res  in  1  synchronous active-high reset.
- exc_valid  in  1  synchronous exception reported by the committing instruction.
- exc_code  in  5  ExcCode (Mod 1, TLBL 2, TLBS 3, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12).
- exc_pc  in  32  PC of the faulting instruction.
- exc_bd  in  1  faulting instruction is in a branch delay slot.
- exc_bva_valid  in  1  exc_badvaddr is meaningful.
- exc_badvaddr  in  32  faulting virtual address.
- exc_refill  in  1  TLB miss requiring the refill vector.
- eret  in  1  ERET at the commit point.
- commit_valid  in  1  an instruction is committing this cycle (interrupt insertion point).
- commit_pc  in  32  PC of that instruction.
- commit_bd  in  1  that instruction is in a delay slot.
- hw_int  in  NUM_INT  asynchronous interrupt lines, active-high, level.
- cp0_status, cp0_cause, cp0_epc  in  32 each  current CP0 register values.
- exc_ready  out  1  block is idle and accepts exc_valid/eret/interrupts.
- in_epc, in_status, in_cause, in_badVAddr  out  32 each  write data to CP0.
- we_epc, we_status, we_cause, we_badVAddr  out  1 each  CP0 write strobes.
- flush  out  1  kill all in-flight instructions.
- redirect  out  1  fetch redirect valid.
- redirect_pc  out  32  fetch target.
- int_pending  out  1  a masked-in interrupt is pending.
- exc_count  out  32  exceptions taken (see Optional Feature).

Behaviour:
- Reset (res=1 at a clk edge): state=IDLE; all we_*, flush, redirect=0; redirect_pc=0; in_*=0; synchroniser flops=0; exc_count=0. Reset mid-sequence aborts it with no CP0 write.
- hw_int passes through a 2-flop synchroniser: ip_sync.
- int_pending = |(ip_sync & cp0_status[15:10]) & cp0_status[0] (IE) & ~cp0_status[1] (EXL).
- exc_ready = (state==IDLE).
- FSM states: IDLE, COMMIT, REDIRECT.
- IDLE transitions, checked in priority order exc_valid > interrupt > eret:
  - exc_valid: latch code, pc, bd, badvaddr, bva_valid, refill; go to COMMIT.
  - Interrupt (int_pending & commit_valid): latch code=0, pc=commit_pc, bd=commit_bd, bva_valid=0, refill=0; go to COMMIT.
  - eret: latch kind=ERET; go to COMMIT.
  - Otherwise stay in IDLE; all outputs low.
- COMMIT (exactly 1 cycle), exception or interrupt kind:
  - we_status=1, in_status = cp0_status with bit1=1.
  - we_cause=1, in_cause = cp0_cause with [6:2]=code, [15:10]=ip_sync, [31]=bd (bd forced 0 if EXL was already 1).
  - If cp0_status[1]=0: we_epc=1, in_epc = bd ? pc-4 : pc (mod 2^32). Otherwise we_epc=0.
  - we_badVAddr = bva_valid, in_badVAddr = latched badvaddr.
  - Next state: REDIRECT.
- COMMIT, ERET kind: we_status=1, in_status = cp0_status with bit1=0; other strobes 0; capture target = cp0_epc. Next state: REDIRECT.
- REDIRECT (exactly 1 cycle): flush=1, redirect=1.
  - Exception kind: redirect_pc = (refill & EXL was 0) ? REFILL_VECTOR : EXC_VECTOR.
  - ERET kind: redirect_pc = captured EPC.
  - Next state: IDLE.
- Latency: request at edge N, CP0 strobes in cycle N+1, flush/redirect in cycle N+2, exc_ready high again in cycle N+3.
- Requests while not in IDLE are ignored; the pipeline holds them because exc_ready=0.

Optional Feature:
- Macro: EXC_STATS_EN.
- Defined: exc_count increments by 1 (wraps at 2^32) on every COMMIT cycle of exception or interrupt kind; ERET does not count; cleared by res.
- Undefined: no counter register; exc_count tied to 32'd0.

Test Plan:
- exc_valid, code=10, pc=0x8000_1000, bd=0, status=0x0000_FC01 -> N+1: we_epc=1 in_epc=0x8000_1000, in_cause[6:2]=10, in_status=0x0000_FC03; N+2: flush=1, redirect_pc=0x8000_0180.
- exc_valid, code=2, refill=1, bd=1, pc=0x0040_0008, badvaddr=0x1234_5678, EXL=0 -> in_epc=0x0040_0004, in_cause[31]=1, we_badVAddr=1 in_badVAddr=0x1234_5678, redirect_pc=0x8000_0000.
- Same refill request with status.EXL=1 -> we_epc=0, in_cause[31]=0, redirect_pc=0x8000_0180.
- hw_int[0]=1, status=0x0000_0401, commit_valid at pc=0x100 -> int_pending 2 cycles after assertion; in_cause[6:2]=0, in_cause[10]=1, in_epc=0x100. With IE=0 -> no entry, exc_ready stays 1.
- eret with epc=0x8000_2000, status=0x03 -> N+1: we_status=1 in_status=0x01, we_epc=0; N+2: redirect_pc=0x8000_2000.
- exc_valid, eret and an interrupt in the same cycle -> exception taken; then assert res during the COMMIT cycle -> no redirect, all outputs 0, exc_count=0.
